if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage RISC-V pipeline.
//   - Owns the program counter and drives the address of the combinational instruction ROM.
//   - Registers the returned word into the IF/ID pipeline register, together with its PC and a valid flag.
//   - Accepts stall and flush/redirect requests from the hazard and branch logic.
//   - Inserts a NOP bubble on redirect.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset (word aligned)
//   NOP_INST  32'h0000_0013  Instruction injected on flush/reset (addi x0,x0,0)
// PORTS
//   clk           in   1   Pipeline clock, rising edge
//   arst_n        in   1   Asynchronous reset, active low
//   stall_i       in   1   Hold PC and IF/ID register (load-use hazard, etc.)
//   flush_i       in   1   Redirect taken (branch/jump/trap); squash the fetched word
//   jump_addr_i   in   32  Redirect target, valid when flush_i=1
//   rom_addr_o    out  32  Byte address to the instruction ROM; ROM indexes [31:2]
//   rom_data_i    in   32  Instruction word from the ROM, combinational on rom_addr_o
//   inst_o        out  32  IF/ID instruction
//   inst_addr_o   out  32  IF/ID PC of inst_o
//   inst_valid_o  out  1   IF/ID holds a real (non-bubble) instruction
// BEHAVIOUR
//   - Reset (arst_n=0, async)
//     - pc_q=RESET_PC, inst_o=NOP_INST, inst_addr_o=32'h0, inst_valid_o=0.
//     - Takes effect immediately, mid-operation included.
//     - The first rising edge after deassert fetches from RESET_PC.
//   - rom_addr_o = pc_q (purely combinational, no extra cycle).
//     - Fetch latency is 1 cycle: the word at pc_q appears on inst_o after the next rising edge.
//   - On each rising edge, priority is flush_i > stall_i > normal.
//     - flush_i=1:
//       - pc_q <= {jump_addr_i[31:2],2'b00} (low bits forced to zero).
//       - inst_o <= NOP_INST, inst_addr_o <= 0, inst_valid_o <= 0.
//       - Flush overrides a simultaneous stall_i.
//     - stall_i=1, flush_i=0:
//       - pc_q, inst_o, inst_addr_o and inst_valid_o all hold.
//       - rom_addr_o stays stable.
//     - Normal:
//       - inst_o <= rom_data_i, inst_addr_o <= pc_q, inst_valid_o <= 1.
//       - pc_q <= pc_q + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000, no flag).
//   - The PC is always word aligned; pc_q[1:0] is 2'b00 in every state.
//   - Redirect cost is 1 bubble: the instruction at the target reaches IF/ID one edge after the flush edge.
//   - Stall has unbounded length; there is no internal timeout.
//   - No X propagation: all registers are reset; outputs are never X after reset.
//   - Back-to-back flushes: each one reloads pc_q; the last flush wins; inst_valid_o stays 0 throughout.
// TESTING
//   1. Reset release with RESET_PC=0 and ROM[0..3]=A0..A3
//      -> inst_o = A0, A1, A2 on successive edges;
//      -> inst_addr_o = 0, 4, 8;
//      -> inst_valid_o = 0 then 1.
//   2. stall_i=1 for 3 cycles while pc_q=8
//      -> rom_addr_o stays 8, inst_o/inst_addr_o frozen;
//      -> after release, the next word is from addr 8 with no skip or duplicate.
//   3. flush_i=1 with jump_addr_i=0x40, ROM[16]=B0
//      -> next edge: inst_o=0x00000013, inst_valid_o=0, rom_addr_o=0x40;
//      -> following edge: inst_o=B0, inst_addr_o=0x40.
//   4. flush_i=1 and stall_i=1 together, jump_addr_i=0x23
//      -> pc_q=0x20 (aligned), bubble inserted; the stall is ignored.
//   5. pc_q=0xFFFF_FFFC with no stall or flush
//      -> next rom_addr_o=0x0000_0000;
//      -> inst_addr_o=0xFFFF_FFFC.
//   6. arst_n pulsed low mid-stream (asynchronous to clk)
//      -> outputs go to reset values immediately, before any edge;
//      -> fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the word-aligned PC, drives the combinational ROM
// address and registers the fetched word into the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  // PC and IF/ID address hold only the word index, so alignment is structural.
  logic [29:0] r_pc;
  logic [31:0] r_inst;
  logic [29:0] r_inst_addr;
  logic        r_valid;

  logic [29:0] w_pc_next;
  logic [31:0] w_inst_next;
  logic [29:0] w_inst_addr_next;
  logic        w_valid_next;
  logic        w_unused_bits;

  assign w_unused_bits = ^jump_addr_i[1:0];

  always_comb begin
    w_pc_next        = r_pc;
    w_inst_next      = r_inst;
    w_inst_addr_next = r_inst_addr;
    w_valid_next     = r_valid;
    if (flush_i) begin
      w_pc_next        = jump_addr_i[31:2];
      w_inst_next      = NOP_INST;
      w_inst_addr_next = '0;
      w_valid_next     = 1'b0;
    end else if (!stall_i) begin
      // Word index increment wraps 0xFFFF_FFFC to 0 naturally.
      w_pc_next        = r_pc + 30'd1;
      w_inst_next      = rom_data_i;
      w_inst_addr_next = r_pc;
      w_valid_next     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pc        <= RESET_PC[31:2];
      r_inst      <= NOP_INST;
      r_inst_addr <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_inst      <= w_inst_next;
      r_inst_addr <= w_inst_addr_next;
      r_valid     <= w_valid_next;
    end
  end

  assign rom_addr_o   = {r_pc, 2'b00};
  assign inst_o       = r_inst;
  assign inst_addr_o  = {r_inst_addr, 2'b00};
  assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of directed cycles plus a random tail,
// expected IF/ID contents queued at drive time and checked after each rising edge.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        arst_n;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] jump_addr_i;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .jump_addr_i (jump_addr_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .inst_valid_o(inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: a few fixed words, an address-derived pattern elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    case (idx)
      30'd0:   rom_word = 32'hAAAA_0000;
      30'd1:   rom_word = 32'hAAAA_0001;
      30'd2:   rom_word = 32'hAAAA_0002;
      30'd3:   rom_word = 32'hAAAA_0003;
      30'd16:  rom_word = 32'hBBBB_0000;
      default: rom_word = {2'b11, idx} ^ 32'h0F0F_0F0F;
    endcase
  endfunction

  always_comb rom_data_i = rom_word(rom_addr_o);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] rom;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] jump;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, ".inst"},  inst_o, e.inst);
    check({tag, ".addr"},  inst_addr_o, e.addr);
    check({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, e.valid});
    check({tag, ".rom"},   rom_addr_o, e.rom);
  endtask

  // Monitor: one transaction per edge when something is expected.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_state("edge", e);
      $display("txn t=%0t inst=%08h addr=%08h valid=%0b rom=%08h", $time,
               inst_o, inst_addr_o, inst_valid_o, rom_addr_o);
    end
  end

  // Drive one cycle of inputs and queue what IF/ID must hold after the edge.
  task automatic drive(input logic st, input logic fl, input logic [31:0] j, input exp_t e);
    stall_i     = st;
    flush_i     = fl;
    jump_addr_i = j;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] a,
                              input logic v, input logic [31:0] r);
    exp_t e;
    e.inst = i; e.addr = a; e.valid = v; e.rom = r;
    return e;
  endfunction

  localparam exp_t RST = '{inst: NOP, addr: 32'h0, valid: 1'b0, rom: 32'h0};

  vec_t vecs[20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_pc, m_inst, m_addr;
    logic        m_valid;

    vecs[0]  = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h0),  32'h0, 1'b1, 32'h4)};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h4),  32'h4, 1'b1, 32'h8)};
    vecs[2]  = '{1'b1, 1'b0, 32'h0, mk(rom_word(32'h4),  32'h4, 1'b1, 32'h8)};
    vecs[3]  = '{1'b1, 1'b0, 32'h0, mk(rom_word(32'h4),  32'h4, 1'b1, 32'h8)};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, mk(rom_word(32'h4),  32'h4, 1'b1, 32'h8)};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h8),  32'h8, 1'b1, 32'hC)};
    vecs[6]  = '{1'b0, 1'b1, 32'h40, mk(NOP, 32'h0, 1'b0, 32'h40)};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, mk(32'hBBBB_0000, 32'h40, 1'b1, 32'h44)};
    vecs[8]  = '{1'b1, 1'b1, 32'h23, mk(NOP, 32'h0, 1'b0, 32'h20)};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h20), 32'h20, 1'b1, 32'h24)};
    vecs[10] = '{1'b0, 1'b1, 32'h100, mk(NOP, 32'h0, 1'b0, 32'h100)};
    vecs[11] = '{1'b0, 1'b1, 32'h207, mk(NOP, 32'h0, 1'b0, 32'h204)};
    vecs[12] = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h204), 32'h204, 1'b1, 32'h208)};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFF, mk(NOP, 32'h0, 1'b0, 32'hFFFF_FFFC)};
    vecs[14] = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1, 32'h0)};
    vecs[15] = '{1'b0, 1'b0, 32'h0, mk(32'hAAAA_0000, 32'h0, 1'b1, 32'h4)};
    vecs[16] = '{1'b0, 1'b1, 32'h11, mk(NOP, 32'h0, 1'b0, 32'h10)};
    vecs[17] = '{1'b1, 1'b0, 32'h0, mk(NOP, 32'h0, 1'b0, 32'h10)};
    vecs[18] = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h10), 32'h10, 1'b1, 32'h14)};
    vecs[19] = '{1'b0, 1'b0, 32'h0, mk(rom_word(32'h14), 32'h14, 1'b1, 32'h18)};

    arst_n      = 1'b0;
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    jump_addr_i = 32'h0;

    // Reset held across an edge, then released between edges.
    #22;
    check_state("reset", RST);
    arst_n = 1'b1;
    #1;
    check_state("release", RST);

    for (int i = 0; i < 20; i++) drive(vecs[i].stall, vecs[i].flush, vecs[i].jump, vecs[i].e);

    // Asynchronous reset mid-stream: outputs must clear with no clock edge.
    drive(1'b0, 1'b1, 32'h80, mk(NOP, 32'h0, 1'b0, 32'h80));
    drive(1'b0, 1'b0, 32'h0, mk(rom_word(32'h80), 32'h80, 1'b1, 32'h84));
    #1;
    arst_n = 1'b0;
    #1;
    check_state("async_rst", RST);
    @(posedge clk);
    #2;
    check_state("rst_held", RST);
    arst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, mk(32'hAAAA_0000, 32'h0, 1'b1, 32'h4));
    drive(1'b0, 1'b0, 32'h0, mk(32'hAAAA_0001, 32'h4, 1'b1, 32'h8));

    // Random tail against a behavioural reference.
    m_pc = 32'h8; m_inst = 32'hAAAA_0001; m_addr = 32'h4; m_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic        st, fl;
      logic [31:0] j;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      j  = $urandom();
      if (fl) begin
        m_pc = j & 32'hFFFF_FFFC; m_inst = NOP; m_addr = 32'h0; m_valid = 1'b0;
      end else if (!st) begin
        m_inst = rom_word(m_pc); m_addr = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
      drive(st, fl, j, mk(m_inst, m_addr, m_valid, m_pc));
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
